// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared definitions for the MADDU path: opcode / ALUOp encodings and the
//   multiply-accumulate FSM state encoding.
package mips_pkg;

    localparam logic [5:0] OP_MADDU    = 6'd28;
    localparam logic [1:0] ALUOP_MADDU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2
    } maddu_state_t;

endpackage

// File: rtl/maddu_mul_step.sv
// maddu_mul_step
//   One radix step of the shift-add multiplier. Adds the partial product of
//   the multiplicand and the low multiplier slice to the running product.
//   Purely combinational. Changing the radix only affects this module.
// Ports
//   i_prod    2*WIDTH          running product
//   i_mcand   2*WIDTH          multiplicand, already shifted for this step
//   i_mplier  BITS_PER_CYCLE   low multiplier slice retired this step
//   o_prod    2*WIDTH          next running product (mod 2^(2*WIDTH))
module maddu_mul_step #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [2*WIDTH-1:0]        i_prod,
    input  logic [2*WIDTH-1:0]        i_mcand,
    input  logic [BITS_PER_CYCLE-1:0] i_mplier,
    output logic [2*WIDTH-1:0]        o_prod
);

    localparam int PW = 2*WIDTH + BITS_PER_CYCLE;

    logic [PW-1:0] w_pp;

    // Both operands widened to the full product width so nothing is lost
    // before truncation; the bits above 2*WIDTH are discarded on purpose.
    assign w_pp   = {{BITS_PER_CYCLE{1'b0}}, i_mcand} * {{(2*WIDTH){1'b0}}, i_mplier};
    assign o_prod = i_prod + w_pp[2*WIDTH-1:0];

endmodule

// File: rtl/maddu_unit.sv
// maddu_unit
//   Iterative unsigned multiply-accumulate for MADDU: {HI,LO} += rs*rt.
//   Owns the HI/LO pair, which is also written by MTHI/MTLO while idle.
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   start, flush      launch request (ALUOp==MADDU) / squash of in-flight op
//   op_a, op_b        rs / rt operands, unsigned
//   wr_hi, wr_lo      MTHI / MTLO enables, wr_data their data
//   busy, done        busy in MUL/ACC; done pulses when HI/LO were updated
//   stall             holds IF/ID/EX while busy or while launching
//   hi, lo            HI / LO registers
module maddu_unit
    import mips_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N) + 1;

    maddu_state_t        r_state;
    logic [2*WIDTH-1:0]  r_mcand;
    logic [WIDTH-1:0]    r_mplier;
    logic [2*WIDTH-1:0]  r_prod;
    logic [CW-1:0]       r_cnt;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;
    logic                r_done;
    logic [2*WIDTH-1:0]  w_next_prod;

    maddu_mul_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .i_prod   (r_prod),
        .i_mcand  (r_mcand),
        .i_mplier (r_mplier[BITS_PER_CYCLE-1:0]),
        .o_prod   (w_next_prod)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A write in the launch cycle lands first, so ACC adds onto it.
                    if (wr_hi) r_hi <= wr_data;
                    if (wr_lo) r_lo <= wr_data;
                    if (start && !flush) begin
                        r_mcand  <= {{WIDTH{1'b0}}, op_a};
                        r_mplier <= op_b;
                        r_prod   <= '0;
                        r_cnt    <= CW'(N);
                        r_state  <= MUL;
                    end
                end
                MUL: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else begin
                        r_prod   <= w_next_prod;
                        r_mcand  <= r_mcand << BITS_PER_CYCLE;
                        r_mplier <= r_mplier >> BITS_PER_CYCLE;
                        r_cnt    <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) r_state <= ACC;
                    end
                end
                ACC: begin
                    // Commit is not squashable; carry out of 2*WIDTH is dropped.
                    {r_hi, r_lo} <= {r_hi, r_lo} + r_prod;
                    r_done       <= 1'b1;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy  = (r_state == MUL) || (r_state == ACC);
    assign stall = busy | (start & ~flush);
    assign done  = r_done;
    assign hi    = r_hi;
    assign lo    = r_lo;

endmodule

// File: tb/tb_maddu_unit.sv
module tb_maddu_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, flush, wr_hi, wr_lo;
    logic [31:0] op_a, op_b, wr_data;
    logic        busy, done, stall;
    logic [31:0] hi, lo;

    logic        start4;
    logic [31:0] op_a4, op_b4;
    logic        busy4, done4, stall4;
    logic [31:0] hi4, lo4;
    logic        flush4, wr_hi4, wr_lo4;
    logic [31:0] wr_data4;

    int n_chk  = 0;
    int n_fail = 0;
    int n_bad_start = 0;

    always #5 clk = ~clk;

    maddu_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .op_a(op_a), .op_b(op_b), .wr_hi(wr_hi), .wr_lo(wr_lo),
        .wr_data(wr_data), .busy(busy), .done(done), .stall(stall),
        .hi(hi), .lo(lo)
    );

    maddu_unit #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .flush(flush4),
        .op_a(op_a4), .op_b(op_b4), .wr_hi(wr_hi4), .wr_lo(wr_lo4),
        .wr_data(wr_data4), .busy(busy4), .done(done4), .stall(stall4),
        .hi(hi4), .lo(lo4)
    );

    // start must never arrive while busy; stall is supposed to prevent it
    always @(posedge clk)
        if (rst && busy && start) n_bad_start++;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic h, input logic l, input logic [31:0] d);
        wr_hi = h; wr_lo = l; wr_data = d;
        tick();
        wr_hi = 1'b0; wr_lo = 1'b0;
    endtask

    // Launch a MADDU (optionally with a same-cycle MTLO) and wait for done.
    // cyc = edges after the launch edge until done is seen, bcnt = busy cycles.
    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input logic wl, input logic [31:0] wd,
                       output int cyc, output int bcnt);
        op_a = a; op_b = b; start = 1'b1;
        wr_lo = wl; wr_data = wd;
        #1;
        chk("stall_on_start", {63'd0, stall}, 64'd1);
        tick();
        start = 1'b0; wr_lo = 1'b0;
        cyc = 0; bcnt = 0;
        while (!done && cyc < 100) begin
            if (busy) bcnt++;
            tick();
            cyc++;
        end
    endtask

    int cyc, bcnt;

    initial begin
        rst = 1'b0; start = 0; flush = 0; wr_hi = 0; wr_lo = 0;
        op_a = 0; op_b = 0; wr_data = 0;
        start4 = 0; op_a4 = 0; op_b4 = 0; flush4 = 0; wr_hi4 = 0; wr_lo4 = 0; wr_data4 = 0;
        repeat (2) tick();
        chk("rst_hilo",  {hi, lo}, 64'd0);
        chk("rst_flags", {61'd0, busy, done, stall}, 64'd0);
        rst = 1'b1;
        tick();

        // 1: asynchronous reset mid-cycle
        wr(1'b1, 1'b1, 32'hAAAA_5555);
        chk("mt_both", {hi, lo}, 64'hAAAA5555_AAAA5555);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_hilo",  {hi, lo}, 64'd0);
        chk("async_rst_flags", {61'd0, busy, done, stall}, 64'd0);
        rst = 1'b1;
        tick();

        // 2: 3*5 from zero, fixed 33-cycle latency
        run(32'd3, 32'd5, 1'b0, 32'd0, cyc, bcnt);
        chk("lat_3x5",  cyc, 64'd33);
        chk("busy_3x5", bcnt, 64'd33);
        chk("hilo_3x5", {hi, lo}, 64'd15);
        tick();
        chk("done_once", {63'd0, done}, 64'd0);

        // 3: max operands, then accumulate a second time
        wr(1'b1, 1'b1, 32'd0);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, cyc, bcnt);
        chk("max_1", {hi, lo}, 64'hFFFFFFFE_00000001);
        tick();
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, cyc, bcnt);
        chk("max_2", {hi, lo}, 64'hFFFFFFFC_00000002);
        tick();

        // 4: wrap with carry lost; MTLO in the launch cycle
        wr(1'b1, 1'b1, 32'hFFFF_FFFF);
        run(32'd1, 32'd1, 1'b0, 32'd0, cyc, bcnt);
        chk("wrap", {hi, lo}, 64'd0);
        tick();
        run(32'd2, 32'd3, 1'b1, 32'd7, cyc, bcnt);
        chk("wr_with_start", {hi, lo}, 64'd13);
        tick();

        // start together with flush in IDLE: nothing launched
        start = 1'b1; flush = 1'b1; op_a = 9; op_b = 9;
        #1;
        chk("stall_start_flush", {63'd0, stall}, 64'd0);
        tick();
        start = 1'b0; flush = 1'b0;
        chk("no_launch_on_flush", {63'd0, busy}, 64'd0);

        // 5: flush on the 10th MUL cycle
        wr(1'b1, 1'b0, 32'd0);
        wr(1'b0, 1'b1, 32'h64);
        op_a = 3; op_b = 5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("busy_before_flush", {63'd0, busy}, 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle", {62'd0, busy, done}, 64'd0);
        chk("flush_hilo", {hi, lo}, 64'h64);
        run(32'd3, 32'd5, 1'b0, 32'd0, cyc, bcnt);
        chk("after_flush_lat",  cyc, 64'd33);
        chk("after_flush_hilo", {hi, lo}, 64'h73);
        tick();

        // 6: reset during the 20th MUL cycle
        op_a = 3; op_b = 5; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        #2 rst = 1'b0;
        #1;
        chk("mul_rst_hilo",  {hi, lo}, 64'd0);
        chk("mul_rst_flags", {61'd0, busy, done, stall}, 64'd0);
        rst = 1'b1;
        tick();

        // radix-16 build: 3*5 in 9 edges
        op_a4 = 3; op_b4 = 5; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        cyc = 0;
        while (!done4 && cyc < 100) begin
            tick();
            cyc++;
        end
        chk("r16_lat",  cyc, 64'd9);
        chk("r16_hilo", {hi4, lo4}, 64'd15);

        chk("no_start_while_busy", n_bad_start, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
